// File: rtl/pif_led_pkg.sv
// Shared LED pattern definitions.
// Used by the control logic (which encodes requests) and by led_pattern_gen
// (which decodes them into red/green drive levels).
package pif_led_pkg;

    localparam logic [2:0] LED_OFF         = 3'd0;
    localparam logic [2:0] LED_ALTERNATING = 3'd1;
    localparam logic [2:0] LED_SYNC        = 3'd2;
    localparam logic [2:0] LED_RED         = 3'd3;
    localparam logic [2:0] LED_GREEN       = 3'd4;
    localparam logic [2:0] LED_BOTH        = 3'd5;

    // Returns {red, green} before brightness gating.
    // Codes 6 and 7 are reserved and fall through to off.
    function automatic logic [1:0] led_pattern(input logic [2:0] mode, input logic ph);
        logic [1:0] rg;
        rg = 2'b00;
        case (mode)
            LED_ALTERNATING: rg = {ph, ~ph};
            LED_SYNC:        rg = {ph, ph};
            LED_RED:         rg = 2'b10;
            LED_GREEN:       rg = 2'b01;
            LED_BOTH:        rg = 2'b11;
            default:         rg = 2'b00;
        endcase
        return rg;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter and brightness comparator, shared by both LED colours.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   duty   - brightness; 0 = always off, all-ones = always on
//   pwm_on - combinational on/off gate for the current counter value
module led_pwm #(
    parameter int unsigned PWM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm_on
);

    logic [PWM_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q + PWM_W'(1);
        // The compare alone would leave one dark step at full duty.
        pwm_on = (cnt_q < duty) | (&duty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Red/green LED driver: blink timing, pattern selection and PWM brightness.
// Mode requests are held pending and only applied on a blink-phase boundary so
// the LEDs never change mid-phase.
// Ports:
//   xclk     - system clock, rising edge
//   GSRn     - global reset, asynchronous, active-low
//   mode_i   - requested pattern code (see pif_led_pkg)
//   duty_i   - requested brightness
//   mode_we  - 1-cycle strobe capturing mode_i/duty_i as pending
//   mode_ack - 1-cycle pulse when a request becomes active
//   phase    - current blink phase
//   ledr     - red LED drive, active-high, registered
//   ledg     - green LED drive, active-high, registered
module led_pattern_gen
    import pif_led_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 22,
    parameter int unsigned PWM_W      = 4
) (
    input  logic             xclk,
    input  logic             GSRn,
    input  logic [2:0]       mode_i,
    input  logic [PWM_W-1:0] duty_i,
    input  logic             mode_we,
    output logic             mode_ack,
    output logic             phase,
    output logic             ledr,
    output logic             ledg
);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  phase_q, phase_d;
    logic                  wrap;

    logic [2:0]            pend_mode_q, pend_mode_d;
    logic [PWM_W-1:0]      pend_duty_q, pend_duty_d;
    logic                  pend_vld_q, pend_vld_d;

    logic [2:0]            act_mode_q, act_mode_d;
    logic [PWM_W-1:0]      act_duty_q, act_duty_d;

    logic                  ack_q, ack_d;
    logic                  ledr_q, ledr_d;
    logic                  ledg_q, ledg_d;

    logic                  pwm_on;
    logic [1:0]            rg;

    led_pwm #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk    (xclk),
        .rst_n  (GSRn),
        .duty   (act_duty_q),
        .pwm_on (pwm_on)
    );

    always_comb begin
        presc_d     = presc_q + PRESCALE_W'(1);
        wrap        = &presc_q;
        phase_d     = phase_q ^ wrap;

        pend_mode_d = pend_mode_q;
        pend_duty_d = pend_duty_q;
        pend_vld_d  = pend_vld_q;
        act_mode_d  = act_mode_q;
        act_duty_d  = act_duty_q;
        ack_d       = 1'b0;

        if (wrap) begin
            // A strobe on the boundary cycle goes straight to active and
            // supersedes anything already pending.
            if (mode_we) begin
                act_mode_d = mode_i;
                act_duty_d = duty_i;
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end else if (pend_vld_q) begin
                act_mode_d = pend_mode_q;
                act_duty_d = pend_duty_q;
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end
        end else if (mode_we) begin
            // Last write before the boundary wins.
            pend_mode_d = mode_i;
            pend_duty_d = duty_i;
            pend_vld_d  = 1'b1;
        end

        rg     = led_pattern(act_mode_q, phase_q);
        ledr_d = rg[1] & pwm_on;
        ledg_d = rg[0] & pwm_on;
    end

    always_ff @(posedge xclk or negedge GSRn) begin
        if (!GSRn) begin
            presc_q     <= '0;
            phase_q     <= 1'b0;
            pend_mode_q <= LED_OFF;
            pend_duty_q <= '0;
            pend_vld_q  <= 1'b0;
            act_mode_q  <= LED_OFF;
            act_duty_q  <= '1;
            ack_q       <= 1'b0;
            ledr_q      <= 1'b0;
            ledg_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            pend_mode_q <= pend_mode_d;
            pend_duty_q <= pend_duty_d;
            pend_vld_q  <= pend_vld_d;
            act_mode_q  <= act_mode_d;
            act_duty_q  <= act_duty_d;
            ack_q       <= ack_d;
            ledr_q      <= ledr_d;
            ledg_q      <= ledg_d;
        end
    end

    assign mode_ack = ack_q;
    assign phase    = phase_q;
    assign ledr     = ledr_q;
    assign ledg     = ledg_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a 16-cycle blink half-period.
module tb_led_pattern_gen;

    logic       xclk;
    logic       GSRn;
    logic [2:0] mode_i;
    logic [3:0] duty_i;
    logic       mode_we;
    logic       mode_ack;
    logic       phase;
    logic       ledr;
    logic       ledg;

    int n_cmp;
    int n_err;
    int cyc;   // rising edges since reset release

    led_pattern_gen #(
        .PRESCALE_W (4),
        .PWM_W      (4)
    ) dut (
        .xclk     (xclk),
        .GSRn     (GSRn),
        .mode_i   (mode_i),
        .duty_i   (duty_i),
        .mode_we  (mode_we),
        .mode_ack (mode_ack),
        .phase    (phase),
        .ledr     (ledr),
        .ledg     (ledg)
    );

    initial xclk = 1'b0;
    always #5 xclk = ~xclk;

    always @(posedge xclk or negedge GSRn) begin
        if (!GSRn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int pre_we;    // issue an earlier, overwritten request first
        int pre_mode;
        int mode;
        int duty;
        int pre_on;    // expected LED-high samples before ack, -1 = don't care
        int r0, g0;    // high counts over 16 samples in phase 0
        int r1, g1;    // high counts over 16 samples in phase 1
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge xclk);
        #1;
    endtask

    task automatic wait_mod(input int m);
        bit hit;
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            if (cyc % 16 == m) begin
                hit = 1;
                break;
            end
            step();
        end
        if (!hit) check($sformatf("wait_mod%0d", m), 0, 1);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   acks, ack_cyc, ack_ph, pre_on, pa;
        int   cr[2];
        int   cg[2];
        v = vecs[idx];
        acks = 0; ack_cyc = -1; ack_ph = 0; pre_on = 0;
        cr[0] = 0; cr[1] = 0; cg[0] = 0; cg[1] = 0;

        wait_mod(5);
        if (v.pre_we != 0) begin
            mode_i = 3'(v.pre_mode); duty_i = 4'(v.duty); mode_we = 1'b1;
            step();
            mode_we = 1'b0;
            step();
            step();
        end
        mode_i = 3'(v.mode); duty_i = 4'(v.duty); mode_we = 1'b1;
        step();
        mode_we = 1'b0;

        for (int i = 0; i < 40; i++) begin
            if (mode_ack) begin
                acks++;
                ack_cyc = cyc;
                ack_ph  = int'(phase);
                break;
            end
            pre_on += int'(ledr) + int'(ledg);
            step();
        end
        check($sformatf("v%0d_ack_seen", idx), acks, 1);
        if (ack_cyc < 0) ack_cyc = cyc;
        check($sformatf("v%0d_ack_on_boundary", idx), ack_cyc % 16, 0);
        check($sformatf("v%0d_phase_at_ack", idx), ack_ph, (ack_cyc / 16) % 2);
        if (v.pre_on >= 0) check($sformatf("v%0d_leds_before_ack", idx), pre_on, v.pre_on);

        pa = (ack_cyc / 16) % 2;
        acks = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            acks += int'(mode_ack);
            if (k < 16) begin
                cr[pa] += int'(ledr); cg[pa] += int'(ledg);
            end else begin
                cr[1-pa] += int'(ledr); cg[1-pa] += int'(ledg);
            end
        end
        check($sformatf("v%0d_extra_acks", idx), acks, 0);
        check($sformatf("v%0d_red_ph0", idx), cr[0], v.r0);
        check($sformatf("v%0d_green_ph0", idx), cg[0], v.g0);
        check($sformatf("v%0d_red_ph1", idx), cr[1], v.r1);
        check($sformatf("v%0d_green_ph1", idx), cg[1], v.g1);
    endtask

    initial begin
        int acks, on;
        n_cmp = 0; n_err = 0;
        GSRn = 1'b0; mode_i = '0; duty_i = '0; mode_we = 1'b0;

        //              pre  pmode mode duty pre_on  r0  g0  r1  g1
        vecs[0] = '{0, 0, 1, 15,  0,  0, 16, 16,  0};  // ALT from OFF
        vecs[1] = '{1, 2, 3, 15, -1, 16,  0, 16,  0};  // SYNC overwritten by RED
        vecs[2] = '{0, 0, 5,  4, -1,  4,  4,  4,  4};  // BOTH, duty 4
        vecs[3] = '{0, 0, 5,  0, -1,  0,  0,  0,  0};  // BOTH, duty 0
        vecs[4] = '{0, 0, 2,  8, -1,  0,  0,  8,  8};  // SYNC, duty 8
        vecs[5] = '{0, 0, 4, 15, -1,  0, 16,  0, 16};  // GREEN
        vecs[6] = '{0, 0, 3,  1, -1,  1,  0,  1,  0};  // RED, duty 1
        vecs[7] = '{0, 0, 6, 15, -1,  0,  0,  0,  0};  // reserved
        vecs[8] = '{0, 0, 7, 15, -1,  0,  0,  0,  0};  // reserved
        vecs[9] = '{0, 0, 5, 15, -1, 16, 16, 16, 16};  // BOTH, full

        // Reset held for 5 cycles, then 16 cycles of phase 0.
        repeat (5) step();
        check("rst_ledr", int'(ledr), 0);
        check("rst_ledg", int'(ledg), 0);
        check("rst_ack", int'(mode_ack), 0);
        check("rst_phase", int'(phase), 0);
        GSRn = 1'b1;
        acks = 0; on = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            acks += int'(mode_ack);
            on   += int'(ledr) + int'(ledg);
            if (i == 15) check("phase_before_16", int'(phase), 0);
            if (i == 16) check("phase_at_16", int'(phase), 1);
        end
        check("post_rst_acks", acks, 0);
        check("post_rst_leds", on, 0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Strobe on the wrap cycle: applied at that edge, acked at that edge.
        wait_mod(15);
        mode_i = 3'd4; duty_i = 4'd15; mode_we = 1'b1;
        step();
        mode_we = 1'b0;
        check("coin_ack", int'(mode_ack), 1);
        step();
        check("coin_ack_once", int'(mode_ack), 0);
        check("coin_ledr", int'(ledr), 0);
        check("coin_ledg", int'(ledg), 1);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            acks += int'(mode_ack);
        end
        check("coin_no_late_ack", acks, 0);

        // Reset while a request is pending.
        wait_mod(5);
        mode_i = 3'd1; duty_i = 4'd15; mode_we = 1'b1;
        step();
        mode_we = 1'b0;
        step();
        check("midrst_ledg_before", int'(ledg), 1);
        #2;
        GSRn = 1'b0;
        #1;
        check("midrst_ledr_async", int'(ledr), 0);
        check("midrst_ledg_async", int'(ledg), 0);
        check("midrst_phase_async", int'(phase), 0);
        acks = 0;
        repeat (3) begin
            step();
            acks += int'(mode_ack);
        end
        GSRn = 1'b1;
        on = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            acks += int'(mode_ack);
            on   += int'(ledr) + int'(ledg);
        end
        check("midrst_no_ack", acks, 0);
        check("midrst_mode_off", on, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
